wb_si_master: RTL and testbench

- Wishbone classic single-transfer initiator.
- Drives the slave register interface (cyc/stb/we/adr/dat/sel) of the pattern-generator core wrapper from a simple valid/ready command port.
- Returns read data and status on a valid/ready response port.
- Sits in the test/control path in front of the register slave; one outstanding transfer at a time.

---
 rtl/wb_si_pkg.sv | 14 +
 rtl/wb_si_timeout_cnt.sv | 39 +++
 rtl/wb_si_master.sv | 154 +++++++++++++++
 tb/tb_wb_si_master.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_si_pkg.sv
// Shared types and response status codes for the Wishbone single-transfer initiator.
package wb_si_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [1:0] RSP_OK      = 2'd0;
    localparam logic [1:0] RSP_BUSERR  = 2'd1;
    localparam logic [1:0] RSP_TIMEOUT = 2'd2;

endpackage

// File: rtl/wb_si_timeout_cnt.sv
// Bus-cycle watchdog: counts stalled strobe cycles and flags the cycle in which
// the count reaches LIMIT.
module wb_si_timeout_cnt #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Flag in the stalled cycle whose increment would bring the count to LIMIT,
    // so the strobe is high for exactly LIMIT cycles.
    assign expired_o = en_i && (cnt_q == CW'(LIMIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wb_si_master.sv
// Wishbone classic single-transfer initiator driven by a valid/ready command port.
// Optional bus watchdog enabled by defining WB_SI_MASTER_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | ready for a command; fields captured on cmd_valid_i
// BUS     | cyc/stb asserted with registered fields, waiting for ack/err
// RESP    | response held on rsp_* until rsp_ready_i
module wb_si_master
    import wb_si_pkg::*;
#(
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = 14,
    parameter int SEL_WIDTH      = (DATA_WIDTH + 7) / 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_n_i,

    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_we_i,
    input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
    input  logic [DATA_WIDTH-1:0] cmd_dat_i,
    input  logic [SEL_WIDTH-1:0]  cmd_sel_i,

    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_dat_o,
    output logic [1:0]            rsp_err_o,

    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic                  wb_we_o,
    output logic [ADDR_WIDTH-1:0] wb_adr_o,
    output logic [DATA_WIDTH-1:0] wb_dat_o,
    output logic [SEL_WIDTH-1:0]  wb_sel_o,
    input  logic [DATA_WIDTH-1:0] wb_dat_i,
    input  logic                  wb_ack_i,
    input  logic                  wb_err_i
);

    state_e state_q, state_d;

    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;
    logic [SEL_WIDTH-1:0]  sel_q, sel_d;
    logic [DATA_WIDTH-1:0] rsp_dat_q, rsp_dat_d;
    logic [1:0]            rsp_err_q, rsp_err_d;

    logic timeout_hit;

`ifdef WB_SI_MASTER_TIMEOUT_EN
    logic to_clr;
    logic to_en;

    assign to_clr = (state_q != ST_BUS);
    assign to_en  = (state_q == ST_BUS) && !wb_ack_i && !wb_err_i;

    wb_si_timeout_cnt #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk       (wb_clk_i),
        .rst_n     (wb_rst_n_i),
        .clr_i     (to_clr),
        .en_i      (to_en),
        .expired_o (timeout_hit)
    );
`else
    logic unused_timeout_cycles;

    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
    assign timeout_hit           = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (cmd_valid_i)                         state_d = ST_BUS;
            ST_BUS:  if (wb_ack_i || wb_err_i || timeout_hit) state_d = ST_RESP;
            ST_RESP: if (rsp_ready_i)                         state_d = ST_IDLE;
            default:                                          state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready_o = (state_q == ST_IDLE);
        wb_cyc_o    = (state_q == ST_BUS);
        wb_stb_o    = (state_q == ST_BUS);
        rsp_valid_o = (state_q == ST_RESP);
        wb_we_o     = we_q;
        wb_adr_o    = adr_q;
        wb_dat_o    = dat_q;
        wb_sel_o    = sel_q;
        rsp_dat_o   = rsp_dat_q;
        rsp_err_o   = rsp_err_q;
    end

    // Command capture and response capture; err has priority over ack, and
    // ack has priority over the watchdog.
    always_comb begin
        we_d      = we_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        sel_d     = sel_q;
        rsp_dat_d = rsp_dat_q;
        rsp_err_d = rsp_err_q;
        if ((state_q == ST_IDLE) && cmd_valid_i) begin
            we_d  = cmd_we_i;
            adr_d = cmd_adr_i;
            dat_d = cmd_dat_i;
            sel_d = cmd_sel_i;
        end
        if (state_q == ST_BUS) begin
            if (wb_err_i) begin
                rsp_dat_d = '0;
                rsp_err_d = RSP_BUSERR;
            end else if (wb_ack_i) begin
                rsp_dat_d = we_q ? '0 : wb_dat_i;
                rsp_err_d = RSP_OK;
            end else if (timeout_hit) begin
                rsp_dat_d = '0;
                rsp_err_d = RSP_TIMEOUT;
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            we_q      <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            rsp_dat_q <= '0;
            rsp_err_q <= RSP_OK;
        end else begin
            we_q      <= we_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            sel_q     <= sel_d;
            rsp_dat_q <= rsp_dat_d;
            rsp_err_q <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_wb_si_master.sv
// Self-checking bench for wb_si_master: transaction-level model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_wb_si_master;

    localparam int AW = 12;
    localparam int DW = 14;
    localparam int SW = 2;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid_i, cmd_ready_o, cmd_we_i;
    logic [AW-1:0] cmd_adr_i;
    logic [DW-1:0] cmd_dat_i;
    logic [SW-1:0] cmd_sel_i;
    logic          rsp_valid_o, rsp_ready_i;
    logic [DW-1:0] rsp_dat_o;
    logic [1:0]    rsp_err_o;
    logic          wb_cyc_o, wb_stb_o, wb_we_o;
    logic [AW-1:0] wb_adr_o;
    logic [DW-1:0] wb_dat_o;
    logic [SW-1:0] wb_sel_o;
    logic [DW-1:0] wb_dat_i;
    logic          wb_ack_i, wb_err_i;

    always #5 clk = ~clk;

    wb_si_master #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEL_WIDTH(SW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
        .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i), .cmd_sel_i(cmd_sel_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_dat_o(rsp_dat_o), .rsp_err_o(rsp_err_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
    );

    int n_pass  = 0;
    int n_total = 0;
    int cyc_no  = 0;

    always @(posedge clk) cyc_no <= cyc_no + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- slave and response-ready drivers ----------------
    int            slv_delay = 0;
    int            slv_mode  = 0;   // 0 ack, 1 err, 2 ack+err, 3 silent
    bit            slv_fix   = 1'b0;
    logic [DW-1:0] slv_val   = '0;
    bit            slv_rand  = 1'b0;
    bit            slv_stray = 1'b0;
    bit            rdy_rand  = 1'b0;
    bit            rdy_force = 1'b1;

    initial begin
        int stb_cnt;
        stb_cnt  = 0;
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_dat_i = '0;
        forever begin
            @(posedge clk); #1;
            wb_dat_i = slv_fix ? slv_val : DW'($urandom);
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
            if (wb_stb_o) begin
                if (slv_mode != 3 && stb_cnt >= slv_delay) begin
                    wb_ack_i = (slv_mode == 0 || slv_mode == 2);
                    wb_err_i = (slv_mode == 1 || slv_mode == 2);
                end
                stb_cnt++;
            end else begin
                stb_cnt = 0;
                if (slv_stray) begin
                    wb_ack_i = ($urandom_range(0, 1) == 1);
                    wb_err_i = ($urandom_range(0, 3) == 0);
                end
                if (slv_rand) begin
                    slv_delay = $urandom_range(0, 3);
                    slv_mode  = $urandom_range(0, 2);
`ifdef WB_SI_MASTER_TIMEOUT_EN
                    if ($urandom_range(0, 7) == 0) slv_mode = 3;
`endif
                end
            end
        end
    end

    initial begin
        rsp_ready_i = 1'b0;
        forever begin
            @(posedge clk); #1;
            rsp_ready_i = rdy_rand ? ($urandom_range(0, 2) != 0) : rdy_force;
        end
    end

    // ---------------- behavioural model and per-cycle compare ----------------
    bit            m_busy = 1'b0;
    bit            m_resp = 1'b0;
    logic          m_we;
    logic [AW-1:0] m_adr;
    logic [DW-1:0] m_dat;
    logic [SW-1:0] m_sel;
    logic [DW-1:0] m_rdat;
    logic [1:0]    m_rerr;
    int            m_bus_cycles;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
                check("rst_cyc",       32'(wb_cyc_o),    32'd0);
                check("rst_stb",       32'(wb_stb_o),    32'd0);
                check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
                check("rst_wb_fields", 32'({wb_we_o, wb_adr_o, wb_sel_o}), 32'd0);
                check("rst_wb_dat",    32'(wb_dat_o),    32'd0);
                check("rst_rsp",       32'({rsp_dat_o, rsp_err_o}), 32'd0);
                m_busy = 1'b0;
                m_resp = 1'b0;
            end else begin
                check("cmd_ready", 32'(cmd_ready_o), 32'(!m_busy && !m_resp));
                check("cyc",       32'(wb_cyc_o),    32'(m_busy));
                check("stb",       32'(wb_stb_o),    32'(m_busy));
                check("rsp_valid", 32'(rsp_valid_o), 32'(m_resp));
                if (m_busy) begin
                    check("wb_we",  32'(wb_we_o),  32'(m_we));
                    check("wb_adr", 32'(wb_adr_o), 32'(m_adr));
                    check("wb_dat", 32'(wb_dat_o), 32'(m_dat));
                    check("wb_sel", 32'(wb_sel_o), 32'(m_sel));
                end
                if (m_resp) begin
                    check("rsp_dat", 32'(rsp_dat_o), 32'(m_rdat));
                    check("rsp_err", 32'(rsp_err_o), 32'(m_rerr));
                end
                // advance to what the next edge must produce
                if (m_resp) begin
                    if (rsp_ready_i) m_resp = 1'b0;
                end else if (m_busy) begin
                    if (wb_err_i) begin
                        m_rdat = '0; m_rerr = 2'd1; m_busy = 1'b0; m_resp = 1'b1;
                    end else if (wb_ack_i) begin
                        m_rdat = m_we ? '0 : wb_dat_i; m_rerr = 2'd0;
                        m_busy = 1'b0; m_resp = 1'b1;
                    end else begin
                        m_bus_cycles++;
`ifdef WB_SI_MASTER_TIMEOUT_EN
                        if (m_bus_cycles == TO) begin
                            m_rdat = '0; m_rerr = 2'd2; m_busy = 1'b0; m_resp = 1'b1;
                        end
`endif
                    end
                end else if (cmd_valid_i) begin
                    m_we = cmd_we_i; m_adr = cmd_adr_i; m_dat = cmd_dat_i; m_sel = cmd_sel_i;
                    m_bus_cycles = 0;
                    m_busy = 1'b1;
                end
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic issue(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                         input logic [SW-1:0] sel, output int acc);
        bit got;
        got = 1'b0;
        acc = 0;
        tick();
        cmd_valid_i = 1'b1; cmd_we_i = we; cmd_adr_i = adr; cmd_dat_i = dat; cmd_sel_i = sel;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (cmd_ready_o) begin got = 1'b1; acc = cyc_no; end
        end
        check("cmd_accepted", 32'(got), 32'd1);
        tick();
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_rsp(input int budget, output int rcyc, output int n_stb,
                            output logic [DW-1:0] d, output logic [1:0] e);
        bit seen;
        seen = 1'b0; n_stb = 0; rcyc = 0; d = '0; e = '0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (rsp_valid_o) begin
                seen = 1'b1; rcyc = cyc_no; d = rsp_dat_o; e = rsp_err_o;
            end else if (wb_stb_o) begin
                n_stb++;
            end
        end
        check("rsp_seen", 32'(seen), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_total);
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        int            acc, rcyc, nstb, nrsp;
        logic [DW-1:0] d;
        logic [1:0]    e;

        rst_n = 1'b0;
        cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_adr_i = '0; cmd_dat_i = '0; cmd_sel_i = '0;
        repeat (3) @(posedge clk);
        #2;
        check("lit_rst_ready", 32'(cmd_ready_o), 32'd1);
        check("lit_rst_cyc",   32'(wb_cyc_o),    32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // write, ack on third strobe cycle
        @(negedge clk);
        slv_mode = 0; slv_delay = 2; rdy_force = 1'b1;
        issue(1'b1, 12'h004, 14'h1A5, 2'b11, acc);
        wait_rsp(100, rcyc, nstb, d, e);
        check("wr_rsp_dat", 32'(d), 32'h0);
        check("wr_rsp_err", 32'(e), 32'd0);
        check("wr_stb_cycles", 32'(nstb), 32'd3);

        // read, ack on first strobe cycle: accept cycle, strobe cycle, response cycle
        slv_delay = 0; slv_fix = 1'b1; slv_val = 14'h3FFF;
        issue(1'b0, 12'h010, 14'h0, 2'b01, acc);
        wait_rsp(100, rcyc, nstb, d, e);
        check("rd_rsp_dat", 32'(d), 32'h3FFF);
        check("rd_rsp_err", 32'(e), 32'd0);
        check("rd_latency", 32'(rcyc - acc + 1), 32'd3);
        check("rd_stb_cycles", 32'(nstb), 32'd1);
        slv_fix = 1'b0;

        // ack and err together: err wins
        slv_mode = 2; slv_delay = 1;
        issue(1'b0, 12'h020, 14'h0, 2'b10, acc);
        wait_rsp(100, rcyc, nstb, d, e);
        check("err_rsp_err", 32'(e), 32'd1);
        check("err_rsp_dat", 32'(d), 32'h0);
        check("err_cyc_low", 32'(wb_cyc_o), 32'd0);

        // backpressure with a second command held on the port
        @(negedge clk);
        slv_mode = 0; slv_delay = 1; slv_fix = 1'b1; slv_val = 14'h2B1; rdy_force = 1'b0;
        tick();
        cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_adr_i = 12'h123; cmd_dat_i = '0; cmd_sel_i = 2'b11;
        nstb = 0;
        for (int i = 0; i < 50 && nstb == 0; i++) begin
            @(negedge clk);
            if (cmd_ready_o) nstb = 1;
        end
        check("bp_first_accept", 32'(nstb), 32'd1);
        tick();
        cmd_we_i = 1'b1; cmd_adr_i = 12'h2AA; cmd_dat_i = 14'h155; cmd_sel_i = 2'b10;
        wait_rsp(100, rcyc, nstb, d, e);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check("bp_rsp_valid", 32'(rsp_valid_o), 32'd1);
            check("bp_rsp_dat",   32'(rsp_dat_o),   32'h2B1);
            check("bp_cmd_ready", 32'(cmd_ready_o), 32'd0);
        end
        rdy_force = 1'b1;
        @(negedge clk);
        check("bp_hs_valid", 32'(rsp_valid_o), 32'd1);
        check("bp_hs_ready", 32'(cmd_ready_o), 32'd0);
        @(negedge clk);
        check("bp_ready_after_hs", 32'(cmd_ready_o), 32'd1);
        check("bp_valid_after_hs", 32'(rsp_valid_o), 32'd0);
        @(negedge clk);
        check("bp_second_cyc", 32'(wb_cyc_o), 32'd1);
        check("bp_second_adr", 32'(wb_adr_o), 32'h2AA);
        tick();
        cmd_valid_i = 1'b0;
        wait_rsp(100, rcyc, nstb, d, e);
        check("bp_second_dat", 32'(d), 32'h0);
        check("bp_second_err", 32'(e), 32'd0);
        slv_fix = 1'b0;

        // silent slave
        slv_mode = 3;
`ifdef WB_SI_MASTER_TIMEOUT_EN
        issue(1'b0, 12'h0F0, 14'h0, 2'b11, acc);
        wait_rsp(100, rcyc, nstb, d, e);
        check("to_stb_cycles", 32'(nstb), 32'd16);
        check("to_rsp_err",    32'(e), 32'd2);
        check("to_rsp_dat",    32'(d), 32'h0);
        slv_mode = 0; slv_delay = 15;
        issue(1'b1, 12'h0F1, 14'h3, 2'b01, acc);
        wait_rsp(100, rcyc, nstb, d, e);
        check("to_ack_at_limit_err", 32'(e), 32'd0);
        check("to_ack_at_limit_stb", 32'(nstb), 32'd16);
`else
        issue(1'b0, 12'h0F0, 14'h0, 2'b11, acc);
        repeat (40) @(negedge clk);
        check("noto_stb_high",  32'(wb_stb_o),    32'd1);
        check("noto_no_rsp",    32'(rsp_valid_o), 32'd0);
        slv_mode = 0; slv_delay = 0;
        wait_rsp(100, rcyc, nstb, d, e);
        check("noto_late_ack_err", 32'(e), 32'd0);
`endif

        // reset while the bus cycle is open
        slv_mode = 3;
        issue(1'b1, 12'h3C3, 14'h2AB, 2'b11, acc);
        @(negedge clk);
        check("mid_rst_pre_cyc", 32'(wb_cyc_o), 32'd1);
        tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_cyc",       32'(wb_cyc_o),    32'd0);
        check("mid_rst_stb",       32'(wb_stb_o),    32'd0);
        check("mid_rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        slv_mode = 0; slv_delay = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        nrsp = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rsp_valid_o) nrsp++;
        end
        check("mid_rst_no_rsp", 32'(nrsp), 32'd0);
        slv_fix = 1'b1; slv_val = 14'h0AB;
        issue(1'b0, 12'h011, 14'h0, 2'b01, acc);
        wait_rsp(100, rcyc, nstb, d, e);
        check("post_rst_dat", 32'(d), 32'h0AB);
        check("post_rst_err", 32'(e), 32'd0);
        slv_fix = 1'b0;

        // randomized traffic, checked by the model every cycle
        @(negedge clk);
        slv_rand = 1'b1; slv_stray = 1'b1; rdy_rand = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            tick();
            cmd_valid_i = ($urandom_range(0, 1) == 1);
            cmd_we_i    = ($urandom_range(0, 1) == 1);
            cmd_adr_i   = AW'($urandom);
            cmd_dat_i   = DW'($urandom);
            cmd_sel_i   = SW'($urandom);
        end
        tick();
        cmd_valid_i = 1'b0;
        repeat (60) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
